uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 153 +++++++++++++++
 tb/tb_uart_tx.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte intake; one or two stop bits.
// Optional parity bit (8E1/8O1) is compiled in with `define UART_TX_PARITY_EN.
module uart_tx #(
   parameter int CLKS_PER_BIT = 10000,
   parameter int STOP_BITS    = 1,
   parameter int PARITY_ODD   = 0
) (
   input  logic       clk_i,
   input  logic       nreset_i,
   input  logic       valid_i,
   output logic       ready_o,
   input  logic [7:0] data_i,
   output logic       tx_o,
   output logic       busy_o
);

   localparam int            W_BAUD    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [W_BAUD-1:0] BAUD_LAST = W_BAUD'(CLKS_PER_BIT - 1);
   localparam logic          STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   generate
      if (CLKS_PER_BIT < 4 || (STOP_BITS != 1 && STOP_BITS != 2) ||
          (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
         $error("uart_tx: illegal parameter combination");
      end
   endgenerate

   // Even parity is the XOR of the data bits; odd parity inverts it.
   function automatic logic parity_bit(input logic [7:0] data, input logic odd);
      parity_bit = (^data) ^ odd;
   endfunction

   state_t              r_state;
   logic [W_BAUD-1:0]   r_baud;
   logic [2:0]          r_bit_cnt;
   logic                r_stop_cnt;
   logic [7:0]          r_shift;
   logic                r_tx;
   logic                r_ready;
   logic                r_busy;
   logic                w_bit_end;
`ifdef UART_TX_PARITY_EN
   logic                r_parity;
`endif

   assign w_bit_end = (r_baud == BAUD_LAST);
   assign tx_o      = r_tx;
   assign ready_o   = r_ready;
   assign busy_o    = r_busy;

   // Frame sequencer: state, counters, shift register and registered outputs.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         r_state    <= S_IDLE;
         r_baud     <= '0;
         r_bit_cnt  <= 3'd0;
         r_stop_cnt <= 1'b0;
         r_shift    <= 8'h00;
         r_tx       <= 1'b1;
         r_ready    <= 1'b0;
         r_busy     <= 1'b0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         if (r_state == S_IDLE || w_bit_end) begin
            r_baud <= '0;
         end else begin
            r_baud <= r_baud + W_BAUD'(1);
         end

         case (r_state)
            S_IDLE: begin
               if (valid_i && r_ready) begin
                  r_state    <= S_START;
                  r_shift    <= data_i;
                  r_bit_cnt  <= 3'd0;
                  r_stop_cnt <= 1'b0;
                  r_tx       <= 1'b0;
                  r_ready    <= 1'b0;
                  r_busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
                  r_parity   <= parity_bit(data_i, 1'(PARITY_ODD));
`endif
               end else begin
                  r_tx    <= 1'b1;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b0;
               end
            end
            S_START: begin
               if (w_bit_end) begin
                  r_state <= S_DATA;
                  r_tx    <= r_shift[0];
               end
            end
            S_DATA: begin
               if (w_bit_end) begin
                  if (r_bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= S_PARITY;
                     r_tx    <= r_parity;
`else
                     r_state <= S_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     // Next line level is the bit that shifts into position 0.
                     r_shift   <= {1'b0, r_shift[7:1]};
                     r_tx      <= r_shift[1];
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                  end
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_bit_end) begin
                  r_state <= S_STOP;
                  r_tx    <= 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_bit_end) begin
                  if (r_stop_cnt == STOP_LAST) begin
                     r_state <= S_IDLE;
                     r_tx    <= 1'b1;
                     r_ready <= 1'b1;
                     r_busy  <= 1'b0;
                  end else begin
                     r_stop_cnt <= r_stop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_tx    <= 1'b1;
               r_ready <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (1 stop/even, 2 stop, 1 stop/odd)
// at a short bit time; frames are sampled every cycle and compared bit by bit.
`timescale 1ns/1ps
module tb_uart_tx;

   localparam int CPB = 8;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       valid_a = 1'b0, valid_b = 1'b0, valid_c = 1'b0;
   logic [7:0] data = 8'h00;
   logic       ready_a, tx_a, busy_a;
   logic       ready_b, tx_b, busy_b;
   logic       ready_c, tx_c, busy_c;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) dut_a (
      .clk_i(clk), .nreset_i(nreset), .valid_i(valid_a), .ready_o(ready_a),
      .data_i(data), .tx_o(tx_a), .busy_o(busy_a));

   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(2), .PARITY_ODD(0)) dut_b (
      .clk_i(clk), .nreset_i(nreset), .valid_i(valid_b), .ready_o(ready_b),
      .data_i(data), .tx_o(tx_b), .busy_o(busy_b));

   uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) dut_c (
      .clk_i(clk), .nreset_i(nreset), .valid_i(valid_c), .ready_o(ready_c),
      .data_i(data), .tx_o(tx_c), .busy_o(busy_c));

   function automatic logic tx_of(input int sel);
      case (sel)
         0:       return tx_a;
         1:       return tx_b;
         default: return tx_c;
      endcase
   endfunction

   function automatic logic ready_of(input int sel);
      case (sel)
         0:       return ready_a;
         1:       return ready_b;
         default: return ready_c;
      endcase
   endfunction

   function automatic logic busy_of(input int sel);
      case (sel)
         0:       return busy_a;
         1:       return busy_b;
         default: return busy_c;
      endcase
   endfunction

   task automatic set_valid(input int sel, input logic v);
      case (sel)
         0:       valid_a = v;
         1:       valid_b = v;
         default: valid_c = v;
      endcase
   endtask

   // Frame model: bit 0 is the start bit, unused upper positions read as idle high.
   function automatic logic [11:0] expect_frame(input logic [7:0] b, input logic odd);
      logic [11:0] f;
      f      = 12'hFFF;
      f[0]   = 1'b0;
      f[8:1] = b;
      if (P == 1) f[9] = (^b) ^ odd;
      return f;
   endfunction

   // Called at #1 after a posedge; bounded wait for ready_o.
   task automatic wait_ready(input int sel);
      int n;
      n = 0;
      while (ready_of(sel) !== 1'b1 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (ready_of(sel) !== 1'b1) begin
         errors++;
         $display("FAIL wait_ready dut%0d: ready_o=%b, required 1 within 200 cycles", sel, ready_of(sel));
      end
   endtask

   // Returns at #1 after the accepting edge.
   task automatic send(input int sel, input logic [7:0] b, input bit keep);
      wait_ready(sel);
      data = b;
      set_valid(sel, 1'b1);
      @(posedge clk); #1;
      if (!keep) set_valid(sel, 1'b0);
   endtask

   // Samples one cycle at a time from #1 after the accepting edge.
   task automatic capture(input int sel, input int nbits, output logic [11:0] bits,
                          output int glitches, output int rdy_hi, output int busy_lo);
      logic v;
      bits = 12'hFFF; glitches = 0; rdy_hi = 0; busy_lo = 0;
      for (int b = 0; b < nbits; b++) begin
         for (int c = 0; c < CPB; c++) begin
            v = tx_of(sel);
            if (c == 0) bits[b] = v;
            else if (v !== bits[b]) glitches++;
            if (ready_of(sel) !== 1'b0) rdy_hi++;
            if (busy_of(sel) !== 1'b1) busy_lo++;
            @(posedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      #5002;
      checks++; if (tx_a !== 1'b1)    begin errors++; $display("FAIL reset_tx: got %b, required 1", tx_a); end
      checks++; if (ready_a !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b, required 0", ready_a); end
      checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b, required 0", busy_a); end
      @(negedge clk); nreset = 1'b1;
      @(posedge clk); #1;
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL release_ready: got %b, required 1", ready_a); end
      checks++; if (tx_a !== 1'b1)    begin errors++; $display("FAIL release_tx: got %b, required 1", tx_a); end
      checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL release_busy: got %b, required 0", busy_a); end
   endtask

   task automatic test_single();
      logic [11:0] bits, exp;
      int g, r, bl;
`ifdef UART_TX_PARITY_EN
      exp = 12'hD2A;
`else
      exp = 12'hF2A;
`endif
      send(0, 8'h95, 1'b0);
      data = 8'h6B;
      capture(0, 10 + P, bits, g, r, bl);
      checks++; if (bits !== exp) begin errors++; $display("FAIL single_frame: got %h, required %h", bits, exp); end
      checks++; if (g != 0)  begin errors++; $display("FAIL single_bit_width: %0d off-level cycles, required 0", g); end
      checks++; if (r != 0)  begin errors++; $display("FAIL single_ready_low: %0d cycles high, required 0", r); end
      checks++; if (bl != 0) begin errors++; $display("FAIL single_busy_high: %0d cycles low, required 0", bl); end
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL single_ready_after: got %b, required 1", ready_a); end
      checks++; if (busy_a !== 1'b0)  begin errors++; $display("FAIL single_busy_after: got %b, required 0", busy_a); end
   endtask

   task automatic test_parity();
      logic [11:0] bits;
      int g, r, bl;
      send(2, 8'h95, 1'b0);
      capture(2, 10 + P, bits, g, r, bl);
      checks++; if (bits !== 12'hF2A) begin errors++; $display("FAIL odd_parity_frame: got %h, required %h", bits, 12'hF2A); end
      checks++; if (g != 0) begin errors++; $display("FAIL odd_parity_width: %0d off-level cycles, required 0", g); end
      checks++; if (ready_c !== 1'b1) begin errors++; $display("FAIL odd_parity_ready_after: got %b, required 1", ready_c); end
   endtask

   task automatic test_back_to_back();
      logic [11:0] bits, exp1, exp2;
      int g, r, bl;
      exp1 = expect_frame(8'hA5, 1'b0);
      exp2 = expect_frame(8'h3C, 1'b0);
      send(0, 8'hA5, 1'b1);
      data = 8'h3C;
      capture(0, 10 + P, bits, g, r, bl);
      checks++; if (bits !== exp1) begin errors++; $display("FAIL b2b_frame1: got %h, required %h", bits, exp1); end
      checks++; if (g != 0 || r != 0) begin errors++; $display("FAIL b2b_frame1_timing: glitches=%0d ready_high=%0d, required 0/0", g, r); end
      checks++; if (tx_a !== 1'b1 || ready_a !== 1'b1) begin errors++; $display("FAIL b2b_idle_cycle: tx=%b ready=%b, required 1/1", tx_a, ready_a); end
      @(posedge clk); #1;
      valid_a = 1'b0;
      data = 8'h00;
      capture(0, 10 + P, bits, g, r, bl);
      checks++; if (bits !== exp2) begin errors++; $display("FAIL b2b_frame2: got %h, required %h", bits, exp2); end
      checks++; if (g != 0 || r != 0) begin errors++; $display("FAIL b2b_frame2_timing: glitches=%0d ready_high=%0d, required 0/0", g, r); end
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL b2b_ready_after: got %b, required 1", ready_a); end
   endtask

   task automatic test_stop2();
      logic [11:0] bits, exp;
      int g, r, bl;
`ifdef UART_TX_PARITY_EN
      exp = 12'hC00;
`else
      exp = 12'hE00;
`endif
      send(1, 8'h00, 1'b0);
      capture(1, 11 + P, bits, g, r, bl);
      checks++; if (bits !== exp) begin errors++; $display("FAIL stop2_frame: got %h, required %h", bits, exp); end
      checks++; if (g != 0)  begin errors++; $display("FAIL stop2_width: %0d off-level cycles, required 0", g); end
      checks++; if (r != 0)  begin errors++; $display("FAIL stop2_ready_low: %0d cycles high, required 0", r); end
      checks++; if (ready_b !== 1'b1) begin errors++; $display("FAIL stop2_ready_after: got %b, required 1", ready_b); end
   endtask

   task automatic test_reset_mid();
      logic [11:0] bits, exp;
      int g, r, bl;
      exp = expect_frame(8'h5A, 1'b0);
      send(0, 8'h00, 1'b0);
      repeat ((1 + 3) * CPB + CPB / 2 - 1) @(posedge clk);
      #2;
      checks++; if (tx_a !== 1'b0) begin errors++; $display("FAIL mid_data_bit3: got %b, required 0", tx_a); end
      nreset = 1'b0;
      #1;
      checks++; if (tx_a !== 1'b1)   begin errors++; $display("FAIL mid_reset_tx: got %b, required 1", tx_a); end
      checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_reset_busy: got %b, required 0", busy_a); end
      repeat (3) @(negedge clk);
      nreset = 1'b1;
      @(posedge clk); #1;
      checks++; if (ready_a !== 1'b1) begin errors++; $display("FAIL mid_release_ready: got %b, required 1", ready_a); end
      send(0, 8'h5A, 1'b0);
      capture(0, 10 + P, bits, g, r, bl);
      checks++; if (bits !== exp) begin errors++; $display("FAIL mid_next_frame: got %h, required %h", bits, exp); end
      checks++; if (g != 0 || bl != 0) begin errors++; $display("FAIL mid_next_timing: glitches=%0d busy_low=%0d, required 0/0", g, bl); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_parity();
      test_back_to_back();
      test_stop2();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
